// File: rtl/uart_host_pkg.sv
// Shared constants for the host-side serial adapter: host-port address map,
// status bit position and FSM encodings.
package uart_host_pkg;

  localparam int unsigned HOST_DW    = 32;
  localparam int unsigned HOST_AW    = 3;
  localparam int unsigned HOST_VALID = 31;

  localparam logic [HOST_AW-1:0] HOST_TXPOP  = 3'b000;
  localparam logic [HOST_AW-1:0] HOST_RXSTAT = 3'b100;
  localparam logic [HOST_AW-1:0] HOST_RXPUSH = 3'b100;

  // Host-port FSM
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TXPOP  = 2'd1;
  localparam logic [1:0] ST_RXSTAT = 2'd2;
  localparam logic [1:0] ST_RXPUSH = 2'd3;

  // Serial receiver FSM
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  // start + 8 data + stop
  localparam int unsigned TX_BITS = 10;

endpackage

// File: rtl/uart_host_serial_if.sv
// Console UART host-port bundle; the adapter is the master, the UART the slave.
interface uart_host_serial_if;
  import uart_host_pkg::*;

  logic               uarthostreq;
  logic [HOST_AW-1:0] uarthostaddr;
  logic               uarthostwr;
  logic [HOST_DW-1:0] uarthostwdata;
  logic               uarthostack;
  logic [HOST_DW-1:0] uarthostrdata;

  modport master (
    output uarthostreq, uarthostaddr, uarthostwr, uarthostwdata,
    input  uarthostack, uarthostrdata
  );

  modport slave (
    input  uarthostreq, uarthostaddr, uarthostwr, uarthostwdata,
    output uarthostack, uarthostrdata
  );
endinterface

// File: rtl/uart_serrx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling, framing-error
// detection. Emits a one-cycle byte valid or framing-error pulse.
module uart_serrx
  import uart_host_pkg::*;
#(
  parameter int unsigned CLKDIV  = 434,
  parameter int unsigned CLKDIVW = 16
) (
  input  logic       clk,
  input  logic       busrstn,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam logic [CLKDIVW-1:0] BIT_LAST  = CLKDIVW'(CLKDIV - 1);
  localparam logic [CLKDIVW-1:0] HALF_LAST = CLKDIVW'(CLKDIV / 2 - 1);
  localparam logic [CLKDIVW-1:0] CNT_ONE   = CLKDIVW'(1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               sync3_q, sync3_d;
  logic [2:0]         state_q, state_d;
  logic [CLKDIVW-1:0] cnt_q, cnt_d;
  logic [2:0]         bitn_q, bitn_d;
  logic [7:0]         shift_q, shift_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               cnt_wrap;

  always_comb begin
    sync1_d  = rxd;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitn_d   = bitn_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    cnt_wrap = (cnt_q == BIT_LAST);

    case (state_q)
      RX_IDLE: begin
        // falling edge on the synchronized line
        if (!sync2_q && sync3_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bitn_d  = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bitn_q == 3'd7) state_d = RX_STOP;
          else                bitn_d  = bitn_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_WAIT: begin
        // re-arm only once the line has returned to idle
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!busrstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_host_serial.sv
// Host-side master of the console UART host port: pops TX bytes and shifts
// them out 8N1 on txd, and pushes bytes received on rxd into the RX FIFO.
module uart_host_serial
  import uart_host_pkg::*;
#(
  parameter int unsigned CLKDIV  = 434,
  parameter int unsigned CLKDIVW = 16
) (
  input  logic                clk,
  input  logic                busrstn,
  uart_host_serial_if.master  host,
  output logic                txd,
  input  logic                rxd,
  output logic                rxovr,
  output logic                rxferr
);

  localparam logic [CLKDIVW-1:0] BIT_LAST = CLKDIVW'(CLKDIV - 1);
  localparam logic [CLKDIVW-1:0] CNT_ONE  = CLKDIVW'(1);
  localparam logic [3:0]         BIT_STOP = 4'(TX_BITS - 1);

  logic [1:0]         state_q, state_d;
  logic               req_q, req_d;
  logic               wr_q, wr_d;
  logic [HOST_AW-1:0] addr_q, addr_d;
  logic [HOST_DW-1:0] wdata_q, wdata_d;
  logic               txd_q, txd_d;
  logic               tx_busy_q, tx_busy_d;
  logic [8:0]         tx_shift_q, tx_shift_d;
  logic [CLKDIVW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]         tx_bit_q, tx_bit_d;
  logic               hold_full_q, hold_full_d;
  logic [7:0]         hold_byte_q, hold_byte_d;
  logic               rxovr_q, rxovr_d;

  logic               ack;
  logic [HOST_DW-1:0] rdata;
  logic               unused_rdata;
  logic               tx_start;
  logic               hold_clr;
  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               rx_ferr;

  assign ack          = host.uarthostack;
  assign rdata        = host.uarthostrdata;
  assign unused_rdata = ^rdata[HOST_VALID-1:8];

  uart_serrx #(
    .CLKDIV  (CLKDIV),
    .CLKDIVW (CLKDIVW)
  ) u_serrx (
    .clk      (clk),
    .busrstn  (busrstn),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  // Host-port FSM: RX holding register drains before TX is polled
  always_comb begin
    state_d  = state_q;
    req_d    = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tx_start = 1'b0;
    hold_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          req_d   = 1'b1;
          addr_d  = HOST_RXSTAT;
          wdata_d = '0;
          state_d = ST_RXSTAT;
        end else if (!tx_busy_q) begin
          req_d   = 1'b1;
          addr_d  = HOST_TXPOP;
          wdata_d = '0;
          state_d = ST_TXPOP;
        end
      end
      ST_TXPOP: begin
        if (ack) begin
          tx_start = rdata[HOST_VALID];
          state_d  = ST_IDLE;
        end
      end
      ST_RXSTAT: begin
        if (ack) begin
          if (rdata[HOST_VALID]) begin
            req_d   = 1'b1;
            wr_d    = 1'b1;
            addr_d  = HOST_RXPUSH;
            wdata_d = {24'h0, hold_byte_q};
            state_d = ST_RXPUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RXPUSH: begin
        if (ack) begin
          hold_clr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // TX shifter: stop bit sits in the top of the shifter so it falls out last
  always_comb begin
    txd_d      = txd_q;
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;

    if (tx_start) begin
      tx_busy_d  = 1'b1;
      txd_d      = 1'b0;
      tx_shift_d = {1'b1, rdata[7:0]};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == BIT_STOP) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
    end
  end

  // Holding register: a push completing this cycle frees the slot for a new byte
  always_comb begin
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    rxovr_d     = 1'b0;

    if (rx_valid) begin
      if (hold_full_q && !hold_clr) begin
        rxovr_d = 1'b1;
      end else begin
        hold_full_d = 1'b1;
        hold_byte_d = rx_byte;
      end
    end else if (hold_clr) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!busrstn) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      txd_q       <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      hold_full_q <= 1'b0;
      hold_byte_q <= '0;
      rxovr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      txd_q       <= txd_d;
      tx_busy_q   <= tx_busy_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      hold_full_q <= hold_full_d;
      hold_byte_q <= hold_byte_d;
      rxovr_q     <= rxovr_d;
    end
  end

  assign host.uarthostreq   = req_q;
  assign host.uarthostwr    = wr_q;
  assign host.uarthostaddr  = addr_q;
  assign host.uarthostwdata = wdata_q;
  assign txd                = txd_q;
  assign rxovr              = rxovr_q;
  assign rxferr             = rx_ferr;

endmodule

// File: tb/tb_uart_host_serial.sv
// Directed bench for uart_host_serial with a behavioural console-UART host-port slave.
module tb_uart_host_serial;

  localparam int unsigned CLKDIV = 4;

  logic clk     = 1'b0;
  logic busrstn = 1'b0;
  logic rxd     = 1'b1;
  logic txd, rxovr, rxferr;

  uart_host_serial_if hif ();

  uart_host_serial #(.CLKDIV(CLKDIV), .CLKDIVW(16)) dut (
    .clk     (clk),
    .busrstn (busrstn),
    .host    (hif),
    .txd     (txd),
    .rxd     (rxd),
    .rxovr   (rxovr),
    .rxferr  (rxferr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // slave model state
  logic        pend = 1'b0;
  logic [2:0]  pend_addr = '0;
  logic        pend_wr = 1'b0;
  logic [31:0] pend_wdata = '0;
  logic        prev_req = 1'b0;
  logic        prev_stat = 1'b0;
  logic        space = 1'b1;
  logic [7:0]  tx_q[$];
  int          n_push = 0, n_stat = 0, n_txpoll = 0;
  int          n_b2b = 0, n_bad = 0, n_ovr = 0, n_ferr = 0;
  logic [31:0] last_wdata = '0;
  logic        push_after_stat = 1'b0;
  int unsigned pop_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (CLKDIV) @(negedge clk);
    end
  endtask

  task automatic wait_txd_low(output bit found, input int lim);
    found = 1'b0;
    for (int k = 0; k < lim && !found; k++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
  endtask

  // Host-port slave: acks in the cycle after each req
  initial begin
    hif.uarthostack   = 1'b0;
    hif.uarthostrdata = '0;
    forever begin
      @(negedge clk);
      hif.uarthostack   = pend;
      hif.uarthostrdata = 32'h0;
      if (pend) begin
        if (pend_wr) begin
          n_push++;
          last_wdata      = pend_wdata;
          push_after_stat = prev_stat;
          prev_stat       = 1'b0;
        end else if (pend_addr == 3'b100) begin
          n_stat++;
          hif.uarthostrdata = {space, 31'h0};
          prev_stat = 1'b1;
        end else begin
          n_txpoll++;
          prev_stat = 1'b0;
          if (tx_q.size() > 0) begin
            hif.uarthostrdata = {1'b1, 23'h0, tx_q.pop_front()};
            pop_cyc = cyc;
          end else begin
            hif.uarthostrdata = 32'h0000_005A;
          end
        end
      end
      pend       = (hif.uarthostreq === 1'b1);
      pend_addr  = hif.uarthostaddr;
      pend_wr    = (hif.uarthostwr === 1'b1);
      pend_wdata = hif.uarthostwdata;
      if (pend) begin
        if (prev_req) n_b2b++;
        if (pend_wr ? (pend_addr != 3'b100 || pend_wdata[31:8] != 24'h0)
                    : (pend_addr != 3'b000 && pend_addr != 3'b100)) n_bad++;
      end
      prev_req = pend;
      if (rxovr === 1'b1) n_ovr++;
      if (rxferr === 1'b1) n_ferr++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [63:0] txv, reqv;
  logic [9:0]  fv;
  int unsigned c;
  bit          found;
  int          base, base2, lowcnt;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_req",   64'(hif.uarthostreq),   64'h0);
    chk("rst_wr",    64'(hif.uarthostwr),    64'h0);
    chk("rst_addr",  64'(hif.uarthostaddr),  64'h0);
    chk("rst_wdata", 64'(hif.uarthostwdata), 64'h0);
    chk("rst_txd",   64'(txd),               64'h1);
    chk("rst_pulses", 64'({rxovr, rxferr}),  64'h0);
    busrstn = 1'b1;

    // empty TX FIFO: repeated single-cycle polls, no frame
    base = n_txpoll; lowcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1) lowcnt++;
    end
    chk("empty_polls", 64'((n_txpoll - base) >= 8), 64'h1);
    chk("empty_txd_high", 64'(lowcnt), 64'h0);

    // TX 0x55 frame, bit timing and immediate re-poll
    tx_q.push_back(8'h55);
    wait_txd_low(found, 60);
    chk("tx55_seen", 64'(found), 64'h1);
    c = cyc;
    txv = '0; reqv = '0;
    txv[0] = txd; reqv[0] = hif.uarthostreq;
    for (int i = 1; i < 46; i++) begin
      @(negedge clk);
      txv[i]  = txd;
      reqv[i] = hif.uarthostreq;
    end
    chk("tx55_latency", 64'(c - pop_cyc), 64'h1);
    chk("tx55_frame",   txv,  64'h0000_3FF0_F0F0_F0F0);
    chk("tx55_repoll",  reqv, 64'h0000_1200_0000_0000);

    // RX 0xA3 with space: status read then push
    space = 1'b1;
    send_frame(8'hA3, 1'b1);
    repeat (20) @(negedge clk);
    chk("rxa3_push",   64'(n_push),          64'd1);
    chk("rxa3_stat",   64'(n_stat),          64'd1);
    chk("rxa3_wdata",  64'(last_wdata),      64'h0000_00A3);
    chk("rxa3_order",  64'(push_after_stat), 64'h1);
    base = n_stat;
    repeat (20) @(negedge clk);
    chk("rxa3_hold_clear", 64'(n_stat - base), 64'h0);

    // no space: first frame held, second overruns
    space = 1'b0; base = n_stat; base2 = n_ovr;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC5, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_pulse",   64'(n_ovr - base2),        64'd1);
    chk("ovr_no_push", 64'(n_push),               64'd1);
    chk("ovr_retry",   64'((n_stat - base) >= 3), 64'h1);
    space = 1'b1;
    repeat (30) @(negedge clk);
    chk("ovr_push",       64'(n_push),     64'd2);
    chk("ovr_kept_first", 64'(last_wdata), 64'h0000_003C);

    // framing error, then a one-cycle glitch, then a good frame
    base2 = n_ferr;
    send_frame(8'h81, 1'b0);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    chk("ferr_pulse",   64'(n_ferr - base2), 64'd1);
    chk("ferr_no_push", 64'(n_push),         64'd2);
    base = n_ovr;
    @(negedge clk); rxd = 1'b0;
    @(negedge clk); rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_ferr", 64'(n_ferr - base2), 64'd1);
    chk("glitch_ovr",  64'(n_ovr - base),   64'd0);
    chk("glitch_push", 64'(n_push),         64'd2);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    chk("rearm_push",  64'(n_push),     64'd3);
    chk("rearm_wdata", 64'(last_wdata), 64'h0000_005A);

    // reset in the middle of a TX frame
    tx_q.push_back(8'hF0);
    wait_txd_low(found, 60);
    chk("rsttx_seen", 64'(found), 64'h1);
    repeat (8) @(negedge clk);
    busrstn = 1'b0;
    @(negedge clk);
    chk("rsttx_txd", 64'(txd),             64'h1);
    chk("rsttx_req", 64'(hif.uarthostreq), 64'h0);
    busrstn = 1'b1;
    repeat (10) @(negedge clk);

    // reset during RXSTAT; the late ack (reporting space) must be ignored
    space = 1'b0;
    send_frame(8'h11, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (hif.uarthostreq === 1'b1 && hif.uarthostaddr === 3'b100 && hif.uarthostwr === 1'b0)
        found = 1'b1;
    end
    chk("rstrx_seen", 64'(found), 64'h1);
    busrstn = 1'b0;
    space   = 1'b1;
    @(negedge clk);
    chk("rstrx_req", 64'(hif.uarthostreq), 64'h0);
    chk("rstrx_txd", 64'(txd),             64'h1);
    busrstn = 1'b1;
    repeat (2) @(negedge clk);
    base = n_stat;
    repeat (20) @(negedge clk);
    chk("rstrx_no_stat", 64'(n_stat - base), 64'h0);
    chk("rstrx_no_push", 64'(n_push),        64'd3);

    // normal operation resumes
    tx_q.push_back(8'h0F);
    wait_txd_low(found, 60);
    chk("resume_tx_seen", 64'(found), 64'h1);
    @(negedge clk);
    fv = '0;
    for (int i = 0; i < 10; i++) begin
      fv[i] = txd;
      repeat (CLKDIV) @(negedge clk);
    end
    chk("resume_tx_frame", 64'(fv), 64'h21E);
    send_frame(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    chk("resume_rx_push",  64'(n_push),     64'd4);
    chk("resume_rx_wdata", 64'(last_wdata), 64'h0000_0077);

    chk("no_b2b_req", 64'(n_b2b), 64'h0);
    chk("req_fields", 64'(n_bad), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
